// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: hold levels, FSM states, widths.
package pipe_pkg;

  localparam int HOLD_W = 3;

  // Hold levels, same encoding as the HOLD_BUS consumed by the stage registers
  localparam logic [HOLD_W-1:0] HOLD_NONE  = 3'd0;
  localparam logic [HOLD_W-1:0] HOLD_PC    = 3'd1;
  localparam logic [HOLD_W-1:0] HOLD_IF_ID = 3'd2;
  localparam logic [HOLD_W-1:0] HOLD_ID_EX = 3'd3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Generic wrapping event counter with synchronous active-high clear.
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  // Count enabled cycles, wrapping modulo 2^W; clear has priority
  always_ff @(posedge clk_i) begin
    if (clr_i)     cnt_o <= '0;
    else if (en_i) cnt_o <= cnt_o + W'(1);
  end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush arbiter with jump redirect and stretched jump flush.
// Optional performance counters enabled by defining PIPE_HOLD_CTRL_PERF_EN.
// Note: rst_n_i is active-high despite its name (legacy port name).
module pipe_hold_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,  // 1..15, includes the request cycle
  parameter int CNT_W        = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              jump_flag_i,
  input  logic [31:0]       jump_addr_i,
  input  logic              ex_hold_i,
  input  logic              id_hold_i,
  input  logic              bus_hold_i,
  input  logic              clint_hold_i,
  output logic [HOLD_W-1:0] hold_flag_o,
  output logic              jump_flag_o,
  output logic [31:0]       jump_addr_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  flush_cnt_q;
  logic [31:0] jump_addr_q;
  logic        jump;

  // A jump is never accepted while reset is asserted
  assign jump = jump_flag_i & ~rst_n_i;

  // Flush stretch FSM: reload on every accepted jump, count down in FLUSH
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      jump_addr_q <= '0;
    end else if (jump) begin
      if (FLUSH_CYCLES > 1) begin
        state_q     <= FLUSH;
        flush_cnt_q <= RELOAD;
        jump_addr_q <= jump_addr_i;
      end
    end else if (state_q == FLUSH) begin
      if (flush_cnt_q == 4'd1) begin
        state_q     <= IDLE;
        flush_cnt_q <= '0;
      end else begin
        flush_cnt_q <= flush_cnt_q - 4'd1;
      end
    end
  end

  // Output arbitration: reset > jump > flush stretch > stall priority chain
  always_comb begin
    hold_flag_o = HOLD_NONE;
    jump_flag_o = 1'b0;
    jump_addr_o = jump_addr_q;
    if (rst_n_i) begin
      jump_addr_o = '0;
    end else if (jump) begin
      hold_flag_o = HOLD_ID_EX;
      jump_flag_o = 1'b1;
      jump_addr_o = jump_addr_i;
    end else if (state_q == FLUSH) begin
      hold_flag_o = HOLD_ID_EX;
    end else if (ex_hold_i || clint_hold_i) begin
      hold_flag_o = HOLD_ID_EX;
    end else if (bus_hold_i) begin
      hold_flag_o = HOLD_PC;
    end else if (id_hold_i) begin
      hold_flag_o = HOLD_IF_ID;
    end
  end

`ifdef PIPE_HOLD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_n_i),
    .en_i  (hold_flag_o != HOLD_NONE),
    .cnt_o (stall_q)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_n_i),
    .en_i  (jump_flag_o),
    .cnt_o (flush_q)
  );

  // Counters read as zero for the whole reset window, not just after the edge
  assign stall_cnt_o = rst_n_i ? '0 : stall_q;
  assign flush_cnt_o = rst_n_i ? '0 : flush_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
